// File: rtl/pcm_conditioner.sv
// pcm_conditioner: three-stage sample conditioner between the I2S receiver and
// the 12-bit DAC. Stage 1 removes the microphone DC offset with a first-order
// high-pass filter, stage 2 applies a power-of-two gain with saturation, and
// stage 3 emits offset-binary data with a valid strobe. A retriggerable hold
// counter drives the clip indicator LED.
`timescale 1ns/1ps
module pcm_conditioner #(
  parameter int IN_W      = 24,
  parameter int OUT_W     = 12,
  parameter int DC_K      = 10,
  parameter int CLIP_HOLD = 12_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       gain,
  input  logic             bypass_dc,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             clip_led
);

  // Filter state width, headroom width for the raw filter sum, gain width.
  localparam int W1 = IN_W + 2;
  localparam int WS = W1 + 2;
  localparam int WG = W1 + 7;
  localparam int CW = $clog2(CLIP_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(CLIP_HOLD);

  // Clamp the raw filter sum into the signed W1 range.
  function automatic logic [W1-1:0] sat_w1(input logic [WS-1:0] raw);
    logic [W1-1:0] res;
    if (raw[WS-1:W1-1] == {(WS-W1+1){raw[WS-1]}}) begin
      res = raw[W1-1:0];
    end else if (raw[WS-1]) begin
      res = {1'b1, {(W1-1){1'b0}}};
    end else begin
      res = {1'b0, {(W1-1){1'b1}}};
    end
    return res;
  endfunction

  // Stage 1 state and pipeline registers
  logic [IN_W-1:0]   r_x_prev;
  logic [W1-1:0]     r_y_prev;
  logic [W1-1:0]     r_s1;
  logic              r_v1;
  // Stage 2 registers
  logic [OUT_W-1:0]  r_sat;
  logic              r_clip;
  logic              r_v2;
  // Stage 3 / output registers
  logic [OUT_W-1:0]  r_out_data;
  logic              r_out_valid;
  logic [CW-1:0]     r_cnt;
  logic              r_clip_led;

  // Stage 1 combinational signals
  logic signed [WS-1:0] w_x_ext;
  logic signed [WS-1:0] w_xp_ext;
  logic signed [WS-1:0] w_yp_ext;
  logic signed [WS-1:0] w_yp_shr;
  logic signed [WS-1:0] w_f_raw;
  logic [W1-1:0]        w_f;
  logic [W1-1:0]        w_s1;
  // Stage 2 combinational signals
  logic signed [WG-1:0] w_g_ext;
  logic signed [WG-1:0] w_g;
  logic signed [WG-1:0] w_v;
  logic                 w_fits;
  logic [OUT_W-1:0]     w_sat;
  logic                 w_clip;
  logic [CW-1:0]        w_cnt_next;

  // DC blocker: f = x - x_prev + y_prev - (y_prev >>> DC_K), saturated.
  always_comb begin
    w_x_ext  = {{(WS-IN_W){in_data[IN_W-1]}}, in_data};
    w_xp_ext = {{(WS-IN_W){r_x_prev[IN_W-1]}}, r_x_prev};
    w_yp_ext = {{(WS-W1){r_y_prev[W1-1]}}, r_y_prev};
    w_yp_shr = w_yp_ext >>> DC_K;
    w_f_raw  = w_x_ext - w_xp_ext + w_yp_ext - w_yp_shr;
    w_f      = sat_w1(w_f_raw);
    if (bypass_dc) begin
      w_s1 = w_x_ext[W1-1:0];
    end else begin
      w_s1 = w_f;
    end
  end

  // Stage 1 registers; filter state advances even in bypass for continuity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
      r_s1     <= '0;
      r_v1     <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_x_prev <= in_data;
        r_y_prev <= w_f;
        r_s1     <= w_s1;
      end
    end
  end

  // Gain, rescale to the output width (floor), and saturate with clip flag.
  always_comb begin
    w_g_ext = {{(WG-W1){r_s1[W1-1]}}, r_s1};
    w_g     = w_g_ext <<< gain;
    w_v     = w_g >>> (IN_W - OUT_W);
    w_fits  = (w_v[WG-1:OUT_W-1] == {(WG-OUT_W+1){w_v[WG-1]}});
    if (w_fits) begin
      w_sat = w_v[OUT_W-1:0];
    end else if (w_v[WG-1]) begin
      w_sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end
    w_clip = r_v1 & ~w_fits;
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat  <= '0;
      r_clip <= 1'b0;
      r_v2   <= 1'b0;
    end else begin
      r_v2   <= r_v1;
      r_clip <= w_clip;
      if (r_v1) begin
        r_sat <= w_sat;
      end
    end
  end

  // Stage 3: convert to offset binary by inverting the sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= {1'b1, {(OUT_W-1){1'b0}}};
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_out_data <= {~r_sat[OUT_W-1], r_sat[OUT_W-2:0]};
      end
    end
  end

  // Hold counter next value: reload on clip, otherwise count down to zero.
  always_comb begin
    if (r_clip) begin
      w_cnt_next = HOLD_LD;
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Hold counter and LED; LED uses the next count so it rises with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_clip_led <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_clip_led <= (w_cnt_next != '0);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign clip_led  = r_clip_led;

endmodule

// File: tb/tb_pcm_conditioner.sv
// Directed testbench for pcm_conditioner with hand-computed vectors and a
// behavioural DC-blocker reference for the long filter runs.
`timescale 1ns/1ps
module tb_pcm_conditioner;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_data;
  logic [2:0]  gain;
  logic        bypass_dc;
  logic        out_valid;
  logic [11:0] out_data;
  logic        clip_led;

  int n_assert = 0;
  int n_fail   = 0;

  longint      m_xp;
  longint      m_yp;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];

  pcm_conditioner #(
    .IN_W(24), .OUT_W(12), .DC_K(10), .CLIP_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .gain(gain), .bypass_dc(bypass_dc), .out_valid(out_valid),
    .out_data(out_data), .clip_led(clip_led)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: behavioural filter + gain + saturation on 64-bit integers.
  function automatic logic [11:0] model_step(input logic [23:0] x, input bit byp, input int g);
    longint xs, f, s1, v;
    xs = longint'($signed(x));
    f  = xs - m_xp + m_yp - (m_yp >>> 10);
    if (f > 64'sd33554431) f = 64'sd33554431;
    if (f < -64'sd33554432) f = -64'sd33554432;
    m_xp = xs;
    m_yp = f;
    s1 = byp ? xs : f;
    v  = (s1 <<< g) >>> 12;
    if (v > 64'sd2047) v = 64'sd2047;
    else if (v < -64'sd2048) v = -64'sd2048;
    return 12'(v + 64'sd2048);
  endfunction

  task automatic collect(input string tag);
    logic [11:0] e;
    if (out_valid) begin
      got_q.push_back(out_data);
      if (exp_q.size() == 0) begin
        check({tag, " unexpected out_valid"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check(tag, 32'(out_data), 32'(e));
      end
    end
  endtask

  task automatic run_stream(input int n, input logic [23:0] x, input bit byp, input string tag);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_data   = x;
      bypass_dc = byp;
      exp_q.push_back(model_step(x, byp, 0));
      tick();
      collect(tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 6; i++) begin
      tick();
      collect(tag);
    end
    check({tag, " drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_xp  = 0;
    m_yp  = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic send_one(input logic [23:0] x, input logic [11:0] expv, input string tag);
    in_data  = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, " valid N"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " valid N+1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " valid N+2"}, 32'(out_valid), 32'd1);
    check({tag, " data"}, 32'(out_data), 32'(expv));
    check({tag, " led"}, 32'(clip_led), 32'd0);
    tick();
    check({tag, " strobe width"}, 32'(out_valid), 32'd0);
    check({tag, " hold"}, 32'(out_data), 32'(expv));
  endtask

  initial begin
    int hi;
    int rises;
    int pulses;
    int viol;
    logic prev;
    logic [11:0] fin;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 24'h000000;
    gain      = 3'd0;
    bypass_dc = 1'b1;
    m_xp = 0;
    m_yp = 0;

    // Reset values
    tick();
    check("rst out_data", 32'(out_data), 32'h800);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst clip_led", 32'(clip_led), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst out_valid", 32'(out_valid), 32'd0);

    // Bypass, gain 0
    send_one(24'h7FFFFF, 12'hFFF, "byp max");
    send_one(24'h800000, 12'h000, "byp min");
    send_one(24'h001000, 12'h801, "byp one");
    send_one(24'hFFFFFF, 12'h7FF, "byp neg1");

    // Single clip, gain 1: LED high exactly HOLD cycles
    gain = 3'd1;
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = (i == 0);
      in_data  = 24'h7FFFFF;
      tick();
      if (i == 2) begin
        check("clip1 valid", 32'(out_valid), 32'd1);
        check("clip1 data", 32'(out_data), 32'hFFF);
        check("clip1 led", 32'(clip_led), 32'd1);
      end
      if (clip_led) hi++;
      if (clip_led && !prev) rises++;
      prev = clip_led;
    end
    check("clip1 led cycles", 32'(hi), 32'(HOLD));
    check("clip1 led rises", 32'(rises), 32'd1);
    check("clip1 led off", 32'(clip_led), 32'd0);

    // Retrigger 10 cycles later: hold extends to HOLD after the second clip
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = (i == 0) || (i == 10);
      in_data  = 24'h7FFFFF;
      tick();
      if (i == 12) begin
        check("clip2 data", 32'(out_data), 32'hFFF);
        check("clip2 led", 32'(clip_led), 32'd1);
      end
      if (clip_led) hi++;
      if (clip_led && !prev) rises++;
      prev = clip_led;
    end
    check("clip2 led cycles", 32'(hi), 32'(10 + HOLD));
    check("clip2 led rises", 32'(rises), 32'd1);

    // Mid-stream reset one cycle after a sample is accepted
    in_valid = 1'b1;
    in_data  = 24'h7FFFFF;
    tick();
    in_data  = 24'h001000;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre-rst data", 32'(out_data), 32'hFFF);
    check("pre-rst led", 32'(clip_led), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst data", 32'(out_data), 32'h800);
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst led", 32'(clip_led), 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("flushed sample pulses", 32'(pulses), 32'd0);
    check("flushed data", 32'(out_data), 32'h800);

    // Throughput: 8 back-to-back samples
    gain      = 3'd0;
    bypass_dc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      in_data  = 24'(i * 4096);
      tick();
      if (i >= 2 && i <= 9) begin
        check("thru valid", 32'(out_valid), 32'd1);
        check("thru data", 32'(out_data), 32'(12'h800 + 12'(i - 2)));
      end else begin
        check("thru idle", 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;

    // DC blocker step response
    do_reset();
    gain = 3'd0;
    run_stream(8 * 1024, 24'h100000, 1'b0, "dc");
    drain("dc");
    check("dc count", 32'(got_q.size()), 32'd8192);
    if (got_q.size() > 0) begin
      check("dc first", 32'(got_q[0]), 32'h900);
      viol = 0;
      for (int i = 1; i < got_q.size(); i++) begin
        if (got_q[i] > got_q[i-1]) viol++;
      end
      check("dc monotonic", 32'(viol), 32'd0);
      fin = got_q[got_q.size()-1];
      check("dc final near midscale", 32'((fin >= 12'h7FF) && (fin <= 12'h801)), 32'd1);
    end

    // Bypass toggle: filter state stays continuous
    do_reset();
    run_stream(100, 24'h100000, 1'b0, "tog pre");
    run_stream(10, 24'h100000, 1'b1, "tog byp");
    run_stream(20, 24'h100000, 1'b0, "tog post");
    drain("tog");
    check("tog count", 32'(got_q.size()), 32'd130);
    if (got_q.size() > 110) begin
      check("tog bypass out", 32'(got_q[105]), 32'h900);
      check("tog resumes below bypass", 32'(got_q[110] < 12'h900), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_conditioner.md
# pcm_conditioner

Sample conditioning stage between the I2S microphone receiver and the 12-bit audio DAC. It accepts one signed 24-bit PCM sample per strobe and removes the microphone DC offset with a first-order high-pass filter. It then applies a power-of-two gain with saturation and emits a 12-bit offset-binary sample with a valid strobe for the DAC. It also drives a retriggerable clip-indicator LED.

## Interface
Parameters:
- IN_W, 24, input sample width (signed two's complement)
- OUT_W, 12, output sample width (offset binary)
- DC_K, 10, DC-blocker pole shift; pole = 1 - 2^-DC_K
- CLIP_HOLD, 12_500_000, clk cycles clip_led stays lit after the last clip event (minimum 1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  single-cycle strobe; in_data is valid this cycle
- in_data  input  IN_W  signed PCM sample from the I2S receiver
- gain  input  3  left-shift amount 0..7, sampled with each sample in stage 2
- bypass_dc  input  1  1 = skip the DC blocker; sampled with each sample in stage 1
- out_valid  output  1  single-cycle strobe; out_data updated this cycle
- out_data  output  OUT_W  offset-binary sample to the DAC; holds between strobes
- clip_led  output  1  high while the clip hold counter is nonzero

## Operation
- Three-stage pipeline, each stage advanced by its own valid bit. Full throughput: in_valid may be high every cycle.
- Stage 1, DC blocker. Internal width W1 = IN_W+2, signed.
  - Filter value f = x - x_prev + y_prev - (y_prev >>> DC_K), saturated to the W1 range.
  - On in_valid: x_prev <= x and y_prev <= f, whether or not bypass_dc is set, so filter state stays continuous when bypass is toggled.
  - Stage-1 result s1 = bypass_dc ? sign-extended x : f.
- Stage 2, gain and saturate.
  - g = s1 <<< gain, computed at full width W1+7.
  - v = g >>> (IN_W-OUT_W): arithmetic shift, truncation toward minus infinity.
  - If v > 2^(OUT_W-1)-1 or v < -2^(OUT_W-1), saturate to the limit and flag clip.
- Stage 3, output.
  - out_data <= sat + 2^(OUT_W-1), which is the MSB inverted.
  - out_valid <= 1 for one cycle.
- Clip hold counter.
  - A clip flag from stage 2 loads the counter with CLIP_HOLD. A retrigger reloads it.
  - Otherwise the counter decrements to 0 and stops.
  - clip_led = (counter != 0), registered.
- Reset (asynchronous, immediate):
  - out_data = 2^(OUT_W-1), i.e. 0x800 (midscale/silence)
  - out_valid = 0, clip_led = 0
  - x_prev, y_prev, the hold counter and all pipeline valids = 0
  - Samples in flight are discarded. No out_valid occurs for them after release.

## Timing
- Sample accepted on the rising edge where in_valid = 1 (edge N).
- out_valid is high and out_data carries the result in the cycle after edge N+2, i.e. three registered stages.
- Ordering is preserved; one output per input; no stalls and no backpressure.
- A gain or bypass_dc change affects only samples that reach the relevant stage after the change. It never affects a sample partially.
- A clip on sample N sets clip_led high in the same cycle that sample's out_valid is high.
- After the last clip, clip_led stays high for exactly CLIP_HOLD cycles.
- Clip events on consecutive samples keep clip_led continuously high.

## Test plan
- Reset: hold rst_n low, then release.
  - Required: out_data = 0x800, out_valid = 0, clip_led = 0.
  - Assert rst_n again mid-stream one cycle after in_valid: outputs return to reset values at once and no out_valid pulse appears for that sample.
- Bypass, gain = 0, one sample per strobe:
  - 0x7FFFFF -> 0xFFF
  - 0x800000 -> 0x000
  - 0x001000 -> 0x801
  - 0xFFFFFF -> 0x7FF
  - Each out_valid lands 3 cycles after its in_valid; clip_led stays 0 throughout.
- Saturation and clip LED, CLIP_HOLD = 16, bypass = 1, gain = 1:
  - 0x7FFFFF -> 0xFFF with clip_led = 1; it stays high for exactly 16 cycles, then 0.
  - A second clip at cycle 10 extends the hold to 16 cycles after the second clip.
- DC blocker, bypass = 0, gain = 0, constant 0x100000 for 8·2^DC_K samples:
  - First output is 0x900.
  - Outputs then decrease monotonically (truncation may produce repeats).
  - The final output is within ±1 of 0x800.
- Throughput: in_valid high for 8 consecutive cycles, samples 0x000000, 0x001000 … 0x007000, bypass = 1.
  - Required: 8 consecutive out_valid pulses carrying 0x800 … 0x807, in order.
- Bypass toggle: run the DC test for 100 samples, switch bypass on for 10, then off.
  - The first filtered output after the switch continues the filter sequence with no reset glitch; check against the reference model.
